// File: rtl/hilo_controller.sv
// HI/LO register file plus the multi-cycle multiply/divide engine that feeds it.
// Multiplies wait a fixed latency; divides run a 32-step restoring divider, then a sign-fix cycle.
module hilo_controller #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hilo_read,
  input  logic        write_hi,
  input  logic        write_lo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state, state_next;
  logic [5:0]  count, count_next;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] quo, rem;
  logic        neg_q, neg_r;

  // Operations: op[0]=0 selects the signed flavour for every op code.
  logic        is_div_op;
  logic        accept;
  logic [31:0] rs_mag, rt_mag;
  assign is_div_op = (op == 3'd2) || (op == 3'd3);
  assign accept    = (state == S_IDLE) && start && !flush;
  assign rs_mag    = (!op[0] && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
  assign rt_mag    = (!op[0] && rt_val[31]) ? (32'd0 - rt_val) : rt_val;

  assign busy      = (state != S_IDLE);
  assign stall     = busy & (start | hilo_read | write_hi | write_lo);
  assign dbg_state = state;

  // Multiply result, taken against the current HI/LO for the accumulate forms.
  logic [63:0] ext_a, ext_b, product, acc, mul_result;
  assign ext_a   = op_q[0] ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
  assign ext_b   = op_q[0] ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
  assign product = ext_a * ext_b;
  assign acc     = {hi, lo};

  always_comb begin
    mul_result = product;
    case (op_q[2:1])
      2'b10:   mul_result = acc + product;
      2'b11:   mul_result = acc - product;
      default: mul_result = product;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  logic [32:0] trial;
  logic [31:0] rem_step, quo_step, q_fix, r_fix;
  assign trial = {rem, quo[31]} - {1'b0, b_q};

  always_comb begin
    rem_step = {rem[30:0], quo[31]};
    quo_step = {quo[30:0], 1'b0};
    if (!trial[32]) begin
      rem_step = trial[31:0];
      quo_step = {quo[30:0], 1'b1};
    end
  end

  assign q_fix = neg_q ? (32'd0 - quo) : quo;
  assign r_fix = neg_r ? (32'd0 - rem) : rem;

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = is_div_op ? S_DIV : S_MUL;
          count_next = is_div_op ? 6'd31 : 6'(MUL_LATENCY - 1);
        end
      end
      S_MUL: begin
        if (flush || count == 6'd0) begin
          state_next = S_IDLE;
          count_next = 6'd0;
        end else begin
          count_next = count - 6'd1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_next = S_IDLE;
          count_next = 6'd0;
        end else if (count == 6'd0) begin
          state_next = S_FIX;
        end else begin
          count_next = count - 6'd1;
        end
      end
      S_FIX: begin
        state_next = S_IDLE;
        count_next = 6'd0;
      end
      default: begin
        state_next = S_IDLE;
        count_next = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= 6'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= 32'd0;
      lo    <= 32'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      quo   <= 32'd0;
      rem   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (write_hi) hi <= wdata;
          if (write_lo) lo <= wdata;
          if (start) begin
            op_q  <= op;
            a_q   <= rs_val;
            b_q   <= is_div_op ? rt_mag : rt_val;
            quo   <= rs_mag;
            rem   <= 32'd0;
            neg_q <= !op[0] && (rs_val[31] ^ rt_val[31]);
            neg_r <= !op[0] && rs_val[31];
          end
        end
        S_MUL: begin
          if (count == 6'd0) {hi, lo} <= mul_result;
        end
        S_DIV: begin
          rem <= rem_step;
          quo <= quo_step;
        end
        S_FIX: begin
          // A zero divisor leaves HI/LO as they were.
          if (b_q != 32'd0) begin
            lo <= q_fix;
            hi <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_controller.sv
// Bench for hilo_controller: reference vectors, corner sequences, random traffic vs. a model.
module tb_hilo_controller;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset, start, hilo_read, write_hi, write_lo, flush;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val, wdata;
  logic        busy, stall;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  hilo_controller #(.MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .hilo_read(hilo_read), .write_hi(write_hi), .write_lo(write_lo), .wdata(wdata),
    .flush(flush), .busy(busy), .stall(stall), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: cycles left until the pending result lands, and architectural HI/LO.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  bit          chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic finish_op();
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p, hl;
    if (m_op == 3'd2 || m_op == 3'd3) begin
      if (m_b != 0) begin
        if (m_op == 3'd2) begin
          sa = $signed(m_a); sb = $signed(m_b);
        end else begin
          sa = {32'd0, m_a}; sb = {32'd0, m_b};
        end
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
    end else begin
      if (m_op == 3'd0 || m_op == 3'd4 || m_op == 3'd6) begin
        sa = $signed(m_a); sb = $signed(m_b);
        p = sa * sb;
      end else begin
        p = {32'd0, m_a} * {32'd0, m_b};
      end
      hl = {m_hi, m_lo};
      if (m_op == 3'd0 || m_op == 3'd1)      hl = p;
      else if (m_op == 3'd4 || m_op == 3'd5) hl = hl + p;
      else                                   hl = hl - p;
      m_hi = hl[63:32];
      m_lo = hl[31:0];
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_left = 0; m_hi = 0; m_lo = 0;
    end else if (m_left > 0) begin
      if (flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) finish_op();
      end
    end else if (!flush) begin
      if (write_hi) m_hi = wdata;
      if (write_lo) m_lo = wdata;
      if (start) begin
        m_op = op; m_a = rs_val; m_b = rt_val;
        m_left = (op == 3'd2 || op == 3'd3) ? 33 : L;
      end
    end
  endtask

  // One clock: stall checked mid-cycle, registered outputs checked just after the edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en)
      check("stall", {31'd0, stall},
            {31'd0, (m_left > 0) && (start || hilo_read || write_hi || write_lo)});
    @(posedge clk);
    model_step();
    #1;
    if (chk_en) begin
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("busy", {31'd0, busy}, {31'd0, m_left > 0});
      check("dbg_state_active", {31'd0, dbg_state != 2'd0}, {31'd0, m_left > 0});
    end
  endtask

  task automatic idle_inputs();
    reset = 0; start = 0; op = 0; rs_val = 0; rt_val = 0;
    hilo_read = 0; write_hi = 0; write_lo = 0; wdata = 0; flush = 0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      n_fail++;
      n_cmp++;
      $display("FAIL %s: busy never dropped within 60 cycles", name);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, ihi, ilo, ehi, elo;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;
    logic [31:0] sv_hi, sv_lo;

    tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        32'd0,    32'd0,        32'hFFFFFFFF, 32'hFFFFFFFE, L};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'd0,    32'd0,        32'h00000001, 32'hFFFFFFFE, L};
    tbl[2]  = '{3'd3, 32'd100,      32'd7,        32'd0,    32'd0,        32'd2,        32'd14,       33};
    tbl[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'd0,    32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    tbl[4]  = '{3'd4, 32'd1,        32'd1,        32'd0,    32'hFFFFFFFF, 32'd1,        32'd0,        L};
    tbl[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd5,    32'd6,        32'd0,        32'h80000000, 33};
    tbl[6]  = '{3'd3, 32'd1234,     32'd0,        32'h11,   32'h22,       32'h11,       32'h22,       33};
    tbl[7]  = '{3'd7, 32'd1,        32'd1,        32'd0,    32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, L};
    tbl[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd0,    32'd0,        32'd1,        32'hFFFFFFFD, 33};
    tbl[9]  = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,    32'd0,        32'hFFFFFFFE, 32'd1,        L};
    tbl[10] = '{3'd6, 32'hFFFFFFFF, 32'd2,        32'd0,    32'd5,        32'd0,        32'd7,        L};

    idle_inputs();
    reset = 1;
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    tick();
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // Reference vectors: preload HI/LO, issue, time the busy window, compare results.
    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      write_hi = 1; wdata = tbl[i].ihi; tick();
      write_hi = 0; write_lo = 1; wdata = tbl[i].ilo; tick();
      write_lo = 0;
      start = 1; op = tbl[i].op; rs_val = tbl[i].rs; rt_val = tbl[i].rt;
      tick();
      start = 0;
      wait_done($sformatf("vec%0d", i), n);
      check($sformatf("vec%0d_latency", i), n, tbl[i].lat);
      check($sformatf("vec%0d_hi", i), hi, tbl[i].ehi);
      check($sformatf("vec%0d_lo", i), lo, tbl[i].elo);
    end

    // DIV in flight, MFHI waits from cycle 5, flush at cycle 10 abandons it.
    idle_inputs();
    sv_hi = hi; sv_lo = lo;
    start = 1; op = 3'd2; rs_val = 32'd1000; rt_val = 32'd3;
    tick();
    start = 0;
    for (int c = 1; c <= 10; c++) begin
      hilo_read = (c >= 5);
      flush = (c == 10);
      #1;
      if (c >= 5) check($sformatf("read_stall_c%0d", c), {31'd0, stall}, 32'd1);
      tick();
    end
    idle_inputs();
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, sv_hi);
    check("flush_lo", lo, sv_lo);

    // Reset at cycle 3 of a MULT.
    start = 1; op = 3'd0; rs_val = 32'd9; rt_val = 32'd9;
    tick();
    start = 0;
    tick(); tick();
    reset = 1; tick();
    reset = 0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    repeat (4) tick();
    check("midreset_lo_later", lo, 32'd0);

    // MTLO and MULTU in the same idle cycle: write lands now, product later.
    write_lo = 1; wdata = 32'h1234; start = 1; op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    idle_inputs();
    check("wr_start_lo_now", lo, 32'h1234);
    wait_done("wr_start", n);
    check("wr_start_lo_final", lo, 32'd12);
    check("wr_start_hi_final", hi, 32'd0);

    // Flush in IDLE suppresses both the issue and an MTHI.
    flush = 1; start = 1; op = 3'd0; rs_val = 32'd5; rt_val = 32'd5;
    write_hi = 1; wdata = 32'hDEAD;
    tick();
    idle_inputs();
    check("idle_flush_busy", {31'd0, busy}, 32'd0);
    check("idle_flush_hi", hi, 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 3) == 0);
      op        = 3'($urandom_range(0, 7));
      rs_val    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rt_val = 32'd0;
        1:       rt_val = 32'hFFFFFFFF;
        2:       rt_val = 32'($urandom_range(1, 9));
        default: rt_val = $urandom;
      endcase
      hilo_read = ($urandom_range(0, 3) == 0);
      write_hi  = ($urandom_range(0, 7) == 0);
      write_lo  = ($urandom_range(0, 7) == 0);
      wdata     = $urandom;
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end

    idle_inputs();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_controller.md
HILO_CONTROLLER -- requirements
Module: hilo_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 Parameter SHALL be MUL_LATENCY, default 3, multiply cycles from acceptance to HI/LO load (legal 1..8).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  EX-stage mul/div issue valid.
REQ-006 op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
REQ-007 rs_val  in  32  first operand (dividend / multiplicand).
REQ-008 rt_val  in  32  second operand (divisor / multiplier).
REQ-009 hilo_read  in  1  MFHI/MFLO in EX requires HI/LO.
REQ-010 write_hi, write_lo  in  1 each  MTHI/MTLO valid.
REQ-011 wdata  in  32  MTHI/MTLO data.
REQ-012 flush  in  1  exception flush; cancels issue and in-flight op.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 stall  out  1  pipeline stall request, combinational.
REQ-015 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-016 FSM states SHALL be IDLE, MUL, DIV and FIX, with a 6-bit step counter.
REQ-017 IDLE with start=1 and flush=0: latch op and operands; ops 0,1,4-7 go to MUL with counter=MUL_LATENCY-1; ops 2,3 go to DIV with counter=31.
REQ-018 The multiply path SHALL be as follows.
  - MUL: counter decrements each cycle.
  - At counter=0 (end of that cycle), load HI/LO and go to IDLE.
  - Accepted in cycle 0: MUL spans cycles 1..MUL_LATENCY; the new value is visible in cycle MUL_LATENCY+1.
REQ-019 Product SHALL be 64-bit: signed for op 0,4,6; unsigned for op 1,5,7.
  - MULT/MULTU: {HI,LO}=product.
  - MADD/MADDU: {HI,LO}+=product.
  - MSUB/MSUBU: {HI,LO}-=product.
  - All results are modulo 2^64.
REQ-020 The divide path SHALL be as follows.
  - DIV: restoring division on magnitudes (signed ops take absolute values at acceptance), one quotient bit per cycle, 32 cycles.
  - Then one FIX cycle, which loads LO=quotient and HI=remainder and goes to IDLE.
  - Accepted in cycle 0: result is visible in cycle 34.
REQ-021 Signed divide sign rules SHALL be as follows.
  - Quotient is negative iff operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-022 Divisor zero SHALL run the full 34-cycle sequence and leave HI/LO unchanged.
REQ-023 stall SHALL equal busy & (start | hilo_read | write_hi | write_lo).
  - start while busy is not accepted.
  - The requester holds start until stall=0.
REQ-024 write_hi/write_lo in IDLE SHALL load hi/lo from wdata at the clock edge; while busy the write is stalled.
REQ-025 start and write_hi/write_lo together in IDLE SHALL both take effect: the write applies now, and the operation result later overwrites it.
REQ-026 flush SHALL take priority.
  - In IDLE, start is ignored.
  - In MUL/DIV/FIX, go to IDLE next cycle with HI/LO unchanged.
  - An MTHI/MTLO write in the same cycle is also suppressed.
REQ-027 hi/lo SHALL change only at a MUL/FIX completion or an accepted MTHI/MTLO write.

Reset
REQ-028 reset=1 SHALL force IDLE, counter=0, hi=0, lo=0, busy=0, stall=0 at the next edge, overriding all inputs.
REQ-029 reset asserted mid-operation SHALL abandon the operation with no HI/LO load.

Verification
REQ-030 MULT rs=0xFFFFFFFF, rt=2, MUL_LATENCY=3 -> busy cycles 1-3; cycle 4: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-031 DIVU rs=100, rt=7 -> busy 33 cycles; cycle 34: lo=14, hi=2.
REQ-032 DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 MADD with hi=0, lo=0xFFFFFFFF, rs=1, rt=1 -> hi=1, lo=0.
REQ-034 DIV in flight, hilo_read=1 at cycle 5 -> stall=1 through cycle 33; flush at cycle 10 -> busy=0 cycle 11, hi/lo unchanged.
REQ-035 DIVU rt=0 with hi=0x11, lo=0x22 -> 34 cycles, hi=0x11, lo=0x22; reset at cycle 3 of another MULT -> hi=lo=0, busy=0.
